// File: rtl/sram_fifo_pkg.sv
// Shared constants and helpers for the SRAM-backed first-word-fall-through FIFO.
package sram_fifo_pkg;

   localparam int OBUF_DEPTH = 2;

   typedef logic [1:0] obuf_cnt_t;

   // $clog2 returns 0 for 1; an address still needs one bit.
   function automatic int clog2_safe(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/sram_1r1w.sv
// Dual-port SRAM wrapper: one write port, one read port with a registered read (1-cycle latency).
module sram_1r1w #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 128,
   parameter int ADDR_W = 7
) (
   input  logic              clk_i,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] waddr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic              re_i,
   input  logic [ADDR_W-1:0] raddr_i,
   output logic [DATA_W-1:0] rdata_o
);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [DATA_W-1:0] rdata_q;

   always_ff @(posedge clk_i) begin
      if (we_i) mem[waddr_i] <= wdata_i;
      if (re_i) rdata_q <= mem[raddr_i];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/sram_fwft_fifo_obuf.sv
// Two-entry output buffer in front of the SRAM; the head register drives rd_data directly.
module fifo_obuf
   import sram_fifo_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              flush_i,
   input  logic              push_i,
   input  logic [DATA_W-1:0] data_i,
   input  logic              pop_i,
   output obuf_cnt_t         cnt_o,
   output logic [DATA_W-1:0] head_o
);

   obuf_cnt_t         cnt_q, cnt_d;
   logic [DATA_W-1:0] head_q, head_d;
   logic [DATA_W-1:0] tail_q, tail_d;

   always_comb begin
      cnt_d  = cnt_q;
      head_d = head_q;
      tail_d = tail_q;
      if (flush_i) begin
         cnt_d = '0;
      end else begin
         case ({push_i, pop_i})
            2'b10: begin
               if (cnt_q == 2'd0) head_d = data_i;
               else               tail_d = data_i;
               cnt_d = cnt_q + 2'd1;
            end
            2'b01: begin
               head_d = tail_q;
               cnt_d  = cnt_q - 2'd1;
            end
            2'b11: begin
               if (cnt_q == 2'd1) begin
                  head_d = data_i;
               end else begin
                  head_d = tail_q;
                  tail_d = data_i;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q  <= '0;
         head_q <= '0;
         tail_q <= '0;
      end else begin
         cnt_q  <= cnt_d;
         head_q <= head_d;
         tail_q <= tail_d;
      end
   end

   assign cnt_o  = cnt_q;
   assign head_o = head_q;

endmodule

// File: rtl/sram_fwft_fifo.sv
// Deep FIFO on a 1R1W SRAM with a 2-entry prefetch buffer giving first-word-fall-through output.
module sram_fwft_fifo
   import sram_fifo_pkg::*;
#(
   parameter int DATA_W    = 32,
   parameter int DEPTH     = 128,
   parameter int AF_THRESH = DEPTH - 2,
   parameter int AE_THRESH = 2,
   parameter int LVL_W     = $clog2(DEPTH + 3)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [DATA_W-1:0] wr_data,
   output logic              rd_valid,
   input  logic              rd_ready,
   output logic [DATA_W-1:0] rd_data,
   output logic [LVL_W-1:0]  level,
   output logic              almost_full,
   output logic              almost_empty
);

   localparam int PTR_W = clog2_safe(DEPTH);
   typedef logic [PTR_W-1:0] ptr_t;
   localparam ptr_t PTR_LAST = ptr_t'(DEPTH - 1);

   function automatic ptr_t next_ptr(input ptr_t p);
      return (p == PTR_LAST) ? '0 : p + ptr_t'(1);
   endfunction

   ptr_t              wptr_q, wptr_d;
   ptr_t              rptr_q, rptr_d;
   logic [LVL_W-1:0]  sram_cnt_q, sram_cnt_d;
   logic              inflight_q, inflight_d;
   obuf_cnt_t         obuf_cnt;
   logic [DATA_W-1:0] sram_rdata;
   logic              wr_acc, rd_issue, pop, push;
   logic [2:0]        occ;

   assign wr_ready = ~rst & (sram_cnt_q < LVL_W'(DEPTH));
   assign wr_acc   = wr_valid & wr_ready & ~flush;
   assign rd_valid = (obuf_cnt != 2'd0);
   assign pop      = rd_valid & rd_ready;
   assign occ      = {2'b00, inflight_q} + {1'b0, obuf_cnt};
   // Issue when the returning word will find a free slot, crediting this cycle's pop so streaming has no bubbles.
   assign rd_issue = (sram_cnt_q != '0) & (occ < (3'd2 + {2'b00, pop})) & ~flush;
   assign push     = inflight_q & ~flush;

   always_comb begin
      wptr_d     = wptr_q;
      rptr_d     = rptr_q;
      sram_cnt_d = sram_cnt_q + LVL_W'(wr_acc) - LVL_W'(rd_issue);
      inflight_d = rd_issue;
      if (wr_acc)   wptr_d = next_ptr(wptr_q);
      if (rd_issue) rptr_d = next_ptr(rptr_q);
   end

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wptr_q     <= '0;
         rptr_q     <= '0;
         sram_cnt_q <= '0;
         inflight_q <= 1'b0;
      end else begin
         wptr_q     <= wptr_d;
         rptr_q     <= rptr_d;
         sram_cnt_q <= sram_cnt_d;
         inflight_q <= inflight_d;
      end
   end

   sram_1r1w #(
      .DATA_W(DATA_W),
      .DEPTH (DEPTH),
      .ADDR_W(PTR_W)
   ) u_sram (
      .clk_i  (clk),
      .we_i   (wr_acc),
      .waddr_i(wptr_q),
      .wdata_i(wr_data),
      .re_i   (rd_issue),
      .raddr_i(rptr_q),
      .rdata_o(sram_rdata)
   );

   fifo_obuf #(
      .DATA_W(DATA_W)
   ) u_obuf (
      .clk_i  (clk),
      .rst_i  (rst),
      .flush_i(flush),
      .push_i (push),
      .data_i (sram_rdata),
      .pop_i  (pop),
      .cnt_o  (obuf_cnt),
      .head_o (rd_data)
   );

   assign level        = sram_cnt_q + LVL_W'(inflight_q) + LVL_W'(obuf_cnt);
   assign almost_full  = (level >= LVL_W'(AF_THRESH));
   assign almost_empty = (level <= LVL_W'(AE_THRESH));

endmodule
